// File: rtl/vga_bus_arb_pkg.sv
// Shared types and defaults for the VGA/CPU RAM arbiter.
package vga_bus_arb_pkg;

  localparam int unsigned AwDefault = 16;
  localparam int unsigned DwDefault = 16;
  localparam int unsigned StallCntW = 16;
  localparam int unsigned ViolCntW  = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ACK
  } arb_state_e;

endpackage

// File: rtl/vga_bus_arbiter_if.sv
// Bus bundle for the arbiter: VGA fetch port, CPU port and RAM port.
// slave = arbiter side, master = surrounding system (masters + RAM).
interface vga_bus_arbiter_if
  import vga_bus_arb_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned DW = DwDefault
);

  logic [AW-1:0] i_vga_addr;
  logic          i_vga_cs;
  logic          i_vga_access;
  logic [DW-1:0] o_vga_dat;

  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_dat;
  logic          i_cpu_cs;
  logic          i_cpu_we;
  logic [DW-1:0] o_cpu_dat;
  logic          o_cpu_ack;

  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_dat;
  logic          o_ram_cs;
  logic          o_ram_we;
  logic [DW-1:0] i_ram_dat;

  modport slave (
    input  i_vga_addr, i_vga_cs, i_vga_access,
    output o_vga_dat,
    input  i_cpu_addr, i_cpu_dat, i_cpu_cs, i_cpu_we,
    output o_cpu_dat, o_cpu_ack,
    output o_ram_addr, o_ram_dat, o_ram_cs, o_ram_we,
    input  i_ram_dat
  );

  modport master (
    output i_vga_addr, i_vga_cs, i_vga_access,
    input  o_vga_dat,
    output i_cpu_addr, i_cpu_dat, i_cpu_cs, i_cpu_we,
    input  o_cpu_dat, o_cpu_ack,
    input  o_ram_addr, o_ram_dat, o_ram_cs, o_ram_we,
    output i_ram_dat
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [Width-1:0] o_count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      count_q <= '0;
    end else if (i_inc && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/vga_bus_arbiter.sv
// Two-master RAM arbiter: VGA fetch has fixed priority, CPU fills free slots via cs/ack.
// Define VGA_BUS_ARB_STATS_EN to add o_stall_cnt / o_viol_cnt statistics counters.
module vga_bus_arbiter
  import vga_bus_arb_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned DW = DwDefault
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  vga_bus_arbiter_if.slave     bus
`ifdef VGA_BUS_ARB_STATS_EN
  ,
  output logic [StallCntW-1:0] o_stall_cnt,
  output logic [ViolCntW-1:0]  o_viol_cnt
`endif
);

  arb_state_e    state_q;
  logic          vga_access_q;
  logic          cpu_ack_q;
  logic          cpu_we_q;
  logic [DW-1:0] cpu_dat_q;
  logic [AW-1:0] ram_addr;
  logic          port_free;
  logic          cpu_issue;

  // A slot announced last cycle, or an unannounced strobe now, both lock the CPU out.
  assign port_free = !vga_access_q && !bus.i_vga_cs;
  assign cpu_issue = (state_q == IDLE) && bus.i_cpu_cs && port_free;

  always_comb begin
    ram_addr = bus.i_cpu_addr;
    if (bus.i_vga_cs) begin
      ram_addr = bus.i_vga_addr;
    end
  end

  assign bus.o_ram_addr = ram_addr;
  assign bus.o_ram_dat  = bus.i_cpu_dat;
  assign bus.o_ram_cs   = !i_reset && (bus.i_vga_cs || cpu_issue);
  assign bus.o_ram_we   = !i_reset && cpu_issue && bus.i_cpu_we;
  assign bus.o_vga_dat  = bus.i_ram_dat;
  assign bus.o_cpu_dat  = cpu_dat_q;
  assign bus.o_cpu_ack  = cpu_ack_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      vga_access_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_we_q     <= 1'b0;
      cpu_dat_q    <= '0;
    end else begin
      vga_access_q <= bus.i_vga_access;
      unique case (state_q)
        IDLE: begin
          if (cpu_issue) begin
            cpu_we_q <= bus.i_cpu_we;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (!cpu_we_q) begin
            cpu_dat_q <= bus.i_ram_dat;
          end
          cpu_ack_q <= 1'b1;
          state_q   <= ACK;
        end
        ACK: begin
          cpu_ack_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VGA_BUS_ARB_STATS_EN
  logic stall_inc;
  logic viol_inc;

  assign stall_inc = (state_q == IDLE) && bus.i_cpu_cs && !port_free;
  assign viol_inc  = bus.i_vga_cs && !vga_access_q;

  sat_counter #(
    .Width(StallCntW)
  ) u_stall_cnt (
    .i_clk  (i_clk),
    .i_clr  (i_reset),
    .i_inc  (stall_inc),
    .o_count(o_stall_cnt)
  );

  sat_counter #(
    .Width(ViolCntW)
  ) u_viol_cnt (
    .i_clk  (i_clk),
    .i_clr  (i_reset),
    .i_inc  (viol_inc),
    .o_count(o_viol_cnt)
  );
`endif

endmodule
